if_fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the RISC_V_Processor decode path.
- Owns the fetch PC and drives the combinational instruction-memory read address.
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush the queue and restart fetch at the new PC.

---
 rtl/if_fetch_queue_if.sv | 39 +++
 rtl/if_fetch_queue.sv | 111 +++++++++++
 tb/tb_if_fetch_queue.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: redirect, instruction-memory and decode-handshake signals of if_fetch_queue.
// With FETCH_HALT_EN defined the bundle also carries the halted status bit.
interface if_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            redirect_valid;
    logic [63:0]     redirect_pc;
    logic [63:0]     imem_addr;
    logic [31:0]     imem_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [63:0]     out_pc;
    logic [CntW-1:0] count;

`ifdef FETCH_HALT_EN
    logic            halted;

    modport master (
        input  redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, count, halted
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, count, halted
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, count
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, count
    );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the fetch PC and buffers {pc, instr} pairs in a DEPTH-entry FIFO for decode.
// Define FETCH_HALT_EN to stop fetching after a queued ECALL until the next redirect.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic              clk,
    input logic              reset,
    if_fetch_queue_if.master bus
);
    localparam int unsigned     PtrW = $clog2(DEPTH);
    localparam int unsigned     CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [63:0]     pc_mem_q [DEPTH];
    logic [63:0]     pc_mem_d [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic            pop, push, fetch_en, head_valid;

`ifdef FETCH_HALT_EN
    localparam logic [31:0] Ecall = 32'h0000_0073;
    logic halted_q, halted_d;
    assign fetch_en   = ~halted_q;
    assign bus.halted = halted_q;
`else
    assign fetch_en = 1'b1;
`endif

    assign head_valid = (count_q != '0);
    assign pop        = head_valid & bus.out_ready;
    // A full queue can still accept the fetch when the head leaves on the same edge.
    assign push       = ~bus.redirect_valid & fetch_en & ((count_q < Full) | pop);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
`ifdef FETCH_HALT_EN
        halted_d    = halted_q;
`endif
        if (bus.redirect_valid) begin
            // Any entry popped this cycle already belongs to decode; the rest is dropped.
            fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
`ifdef FETCH_HALT_EN
            halted_d   = 1'b0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = bus.imem_data;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                fetch_pc_d            = fetch_pc_q + 64'd4;
`ifdef FETCH_HALT_EN
                if (bus.imem_data == Ecall) begin
                    halted_d = 1'b1;
                end
`endif
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pc_mem_q    <= '{default: '0};
            instr_mem_q <= '{default: '0};
`ifdef FETCH_HALT_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
`ifdef FETCH_HALT_EN
            halted_q    <= halted_d;
`endif
        end
    end

    assign bus.imem_addr = fetch_pc_q;
    assign bus.count     = count_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.out_instr = head_valid ? instr_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: table-driven vectors, hand sequences for reset/redirect/halt corners, and
// random traffic checked against a queue-based reference model of the fetch front end.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          checks = 0;
    int          passed = 0;
    logic [63:0] ecall_addr = '1;

    if_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: fixed word at 0, hashed elsewhere, never ECALL by accident.
    function automatic logic [31:0] imem_word(input logic [63:0] a);
        logic [31:0] w;
        if (a == 64'h0) return 32'h00A0_0093;
        w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        w[1:0] = 2'b11;
        if (w == ECALL) w = 32'h0000_0093;
        return w;
    endfunction

    function automatic logic [31:0] fetch_word(input logic [63:0] a);
        return (a == ecall_addr) ? ECALL : imem_word(a);
    endfunction

    assign bus.imem_data = (bus.imem_addr == ecall_addr) ? ECALL : imem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference model: a plain queue of fetched pairs plus the next fetch address.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_halted;

    task automatic model_reset();
        mq.delete();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input logic rv, input logic [63:0] rpc, input logic rdy);
        logic [31:0] w;
        logic        did_pop;
        did_pop = (mq.size() != 0) && rdy;
        if (rv) begin
            mq.delete();
            m_pc     = {rpc[63:2], 2'b00};
            m_halted = 1'b0;
        end else begin
            if (did_pop) void'(mq.pop_front());
            if (mq.size() < DEPTH && !m_halted) begin
                w = fetch_word(m_pc);
                mq.push_back('{pc: m_pc, instr: w});
`ifdef FETCH_HALT_EN
                if (w == ECALL) m_halted = 1'b1;
`endif
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("rand_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("rand_count", 64'(bus.count), 64'(mq.size()));
        chk("rand_pc", bus.out_pc, h.pc);
        chk("rand_instr", 64'(bus.out_instr), 64'(h.instr));
        chk("rand_addr", bus.imem_addr, m_pc);
`ifdef FETCH_HALT_EN
        chk("rand_halted", 64'(bus.halted), 64'(m_halted));
`endif
    endtask

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        exp_valid;
        int unsigned exp_count;
        logic [63:0] exp_pc;
        logic [63:0] exp_addr;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic rdy,
                                input logic v, input int unsigned c, input logic [63:0] pc,
                                input logic [63:0] a);
        vec_t t;
        t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.exp_valid = v; t.exp_count = c; t.exp_pc = pc; t.exp_addr = a;
        return t;
    endfunction

    vec_t vecs[15];

    initial begin
        logic        rv, rdy;
        logic [63:0] rpc;
        int unsigned n;

        // Each row: inputs held for one edge, then the expected state after that edge.
        vecs[0]  = mk(1'b0, 64'h0,    1'b1, 1'b1, 1, 64'h0,    64'h4);
        vecs[1]  = mk(1'b0, 64'h0,    1'b1, 1'b1, 1, 64'h4,    64'h8);
        vecs[2]  = mk(1'b0, 64'h0,    1'b1, 1'b1, 1, 64'h8,    64'hC);
        vecs[3]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 2, 64'h8,    64'h10);
        vecs[4]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 3, 64'h8,    64'h14);
        vecs[5]  = mk(1'b1, 64'h203,  1'b0, 1'b0, 0, 64'h0,    64'h200);
        vecs[6]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 1, 64'h200,  64'h204);
        vecs[7]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 2, 64'h200,  64'h208);
        vecs[8]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 3, 64'h200,  64'h20C);
        vecs[9]  = mk(1'b0, 64'h0,    1'b0, 1'b1, 4, 64'h200,  64'h210);
        vecs[10] = mk(1'b0, 64'h0,    1'b0, 1'b1, 4, 64'h200,  64'h210);
        vecs[11] = mk(1'b0, 64'h0,    1'b1, 1'b1, 4, 64'h204,  64'h214);
        vecs[12] = mk(1'b0, 64'h0,    1'b0, 1'b1, 4, 64'h204,  64'h214);
        vecs[13] = mk(1'b1, 64'h1000, 1'b1, 1'b0, 0, 64'h0,    64'h1000);
        vecs[14] = mk(1'b0, 64'h0,    1'b1, 1'b1, 1, 64'h1000, 64'h1004);

        do_reset();
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_pc", bus.out_pc, 64'd0);
        chk("reset_instr", 64'(bus.out_instr), 64'd0);
        chk("reset_addr", bus.imem_addr, RESET_PC);
`ifdef FETCH_HALT_EN
        chk("reset_halted", 64'(bus.halted), 64'd0);
`endif

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_instr", i), 64'(bus.out_instr),
                vecs[i].exp_valid ? 64'(imem_word(vecs[i].exp_pc)) : 64'd0);
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
        end

        // Fill with decode stalled, then a single-cycle ready pulse on a full queue.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            n = (i < 4) ? i : 4;
            chk($sformatf("fill%0d_count", i), 64'(bus.count), 64'(n));
            chk($sformatf("fill%0d_addr", i), bus.imem_addr, 64'(4 * n));
            chk($sformatf("fill%0d_pc", i), bus.out_pc, 64'h0);
        end
        drive(1'b0, 64'h0, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        chk("pulse_count", 64'(bus.count), 64'd4);
        chk("pulse_pc", bus.out_pc, 64'h4);
        chk("pulse_addr", bus.imem_addr, 64'h14);

        // Asynchronous reset between edges with two entries queued.
        do_reset();
        tick();
        tick();
        chk("pre_areset_count", 64'(bus.count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_count", 64'(bus.count), 64'd0);
        chk("areset_pc", bus.out_pc, 64'd0);
        chk("areset_addr", bus.imem_addr, RESET_PC);

`ifdef FETCH_HALT_EN
        do_reset();
        ecall_addr = 64'h8;
        drive(1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halt_head%0d", i), bus.out_pc, 64'(4 * i));
        end
        chk("halt_instr", 64'(bus.out_instr), 64'(ECALL));
        chk("halt_set", 64'(bus.halted), 64'd1);
        tick();
        tick();
        chk("halt_drained", 64'(bus.count), 64'd0);
        chk("halt_addr_hold", bus.imem_addr, 64'hC);
        chk("halt_still", 64'(bus.halted), 64'd1);
        drive(1'b1, 64'h40, 1'b1);
        tick();
        chk("halt_clear", 64'(bus.halted), 64'd0);
        chk("halt_redir_addr", bus.imem_addr, 64'h40);
        drive(1'b0, 64'h0, 1'b1);
        tick();
        chk("halt_resume_pc", bus.out_pc, 64'h40);
        ecall_addr = 64'h18;
`endif

        // Random traffic against the reference model, including PC wrap near 2^64.
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            check_model();
            rv  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? {56'hFF_FFFF_FFFF_FFFF, 8'($urandom_range(0, 255))}
                                              : 64'($urandom_range(0, 255));
            if (((c / 16) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
            else                     rdy = ($urandom_range(0, 3) == 0);
            drive(rv, rpc, rdy);
            @(posedge clk);
            model_step(rv, rpc, rdy);
            @(negedge clk);
        end
        check_model();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
